// File: rtl/branch_redirect_ctrl_pkg.sv
// rtl/branch_redirect_ctrl_pkg.sv - table entry layout, redirect states and 2-bit counter helper
package branch_redirect_ctrl_pkg;

  localparam int BRC_PC_W        = 9;
  localparam int BRC_BHT_ENTRIES = 16;
  localparam int BRC_IDX_W       = $clog2(BRC_BHT_ENTRIES);
  localparam int BRC_TAG_W       = BRC_PC_W - BRC_IDX_W - 2;

  localparam logic [1:0] CTR_RESET = 2'b01;
  localparam logic [1:0] CTR_ALLOC = 2'b10;

  typedef struct packed {
    logic                 valid;
    logic [BRC_TAG_W-1:0] tag;
    logic [BRC_PC_W-1:0]  target;
    logic [1:0]           ctr;
  } bht_entry_t;

  typedef enum logic {
    RUN   = 1'b0,
    REDIR = 1'b1
  } redir_state_e;

  function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
    logic [1:0] res;
    res = ctr;
    if (taken && ctr != 2'b11) begin
      res = ctr + 2'd1;
    end else if (!taken && ctr != 2'b00) begin
      res = ctr - 2'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/branch_redirect_ctrl_if.sv
// rtl/branch_redirect_ctrl_if.sv - fetch/EX/redirect signal bundle between pipeline and redirect controller
interface branch_redirect_ctrl_if #(
  parameter int PC_W  = 9,
  parameter int CNT_W = 16
);

  logic             stall;
  logic [PC_W-1:0]  if_pc;
  logic             pred_taken;
  logic [PC_W-1:0]  pred_target;
  logic             ex_valid;
  logic             ex_branch;
  logic             ex_jump;
  logic [PC_W-1:0]  ex_pc;
  logic             ex_pc_sel;
  logic [31:0]      ex_br_pc;
  logic             ex_pred_taken;
  logic [PC_W-1:0]  ex_pred_target;
  logic             redirect;
  logic [PC_W-1:0]  redirect_pc;
  logic             flush_if_id;
  logic             flush_id_ex;
  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] mispredict_cnt;

  modport slave (
    input  stall, if_pc, ex_valid, ex_branch, ex_jump, ex_pc, ex_pc_sel, ex_br_pc,
           ex_pred_taken, ex_pred_target,
    output pred_taken, pred_target, redirect, redirect_pc, flush_if_id, flush_id_ex,
           branch_cnt, mispredict_cnt
  );

  modport master (
    output stall, if_pc, ex_valid, ex_branch, ex_jump, ex_pc, ex_pc_sel, ex_br_pc,
           ex_pred_taken, ex_pred_target,
    input  pred_taken, pred_target, redirect, redirect_pc, flush_if_id, flush_id_ex,
           branch_cnt, mispredict_cnt
  );

endinterface

// File: rtl/branch_redirect_ctrl_bht_array.sv
// rtl/branch_redirect_ctrl_bht_array.sv - direct-mapped BHT/BTB storage
// Combinational reads see pre-write contents; the single write lands on the clock edge.
module branch_redirect_ctrl_bht_array
  import branch_redirect_ctrl_pkg::*;
#(
  parameter int ENTRIES = BRC_BHT_ENTRIES,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [IDX_W-1:0] if_idx_i,
  output bht_entry_t       if_entry_o,
  input  logic [IDX_W-1:0] ex_idx_i,
  output bht_entry_t       ex_entry_o,
  input  logic             wr_en_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  bht_entry_t       wr_entry_i
);

  bht_entry_t tbl_q [ENTRIES];

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        tbl_q[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: CTR_RESET};
      end
    end else if (wr_en_i) begin
      tbl_q[wr_idx_i] <= wr_entry_i;
    end
  end

  assign if_entry_o = tbl_q[if_idx_i];
  assign ex_entry_o = tbl_q[ex_idx_i];

endmodule

// File: rtl/branch_redirect_ctrl.sv
// rtl/branch_redirect_ctrl.sv - IF branch prediction, EX resolution check, registered redirect/flush
// and counter training with branch/mispredict statistics.
module branch_redirect_ctrl
  import branch_redirect_ctrl_pkg::*;
#(
  parameter int PC_W        = BRC_PC_W,
  parameter int BHT_ENTRIES = BRC_BHT_ENTRIES,
  parameter int CNT_W       = 16
) (
  input logic                   clk_i,
  input logic                   reset_i,
  branch_redirect_ctrl_if.slave bus
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);
  localparam int TAG_W = PC_W - IDX_W - 2;

  redir_state_e     state_q, state_d;
  logic [PC_W-1:0]  redirect_pc_q, redirect_pc_d;
  logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0] mis_cnt_q, mis_cnt_d;

  logic [IDX_W-1:0] if_idx, ex_idx;
  logic [TAG_W-1:0] if_tag, ex_tag;
  bht_entry_t       if_entry, ex_entry, wr_entry;
  logic             wr_en;
  logic             if_hit, ex_hit;
  logic             resolve, ctl, mis, train_taken;
  logic [PC_W-1:0]  br_tgt, fix_pc;
  logic             unused_bits;

  assign if_idx = bus.if_pc[IDX_W+1:2];
  assign if_tag = bus.if_pc[PC_W-1:IDX_W+2];
  assign ex_idx = bus.ex_pc[IDX_W+1:2];
  assign ex_tag = bus.ex_pc[PC_W-1:IDX_W+2];

  branch_redirect_ctrl_bht_array #(
    .ENTRIES (BHT_ENTRIES),
    .IDX_W   (IDX_W)
  ) u_bht (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .if_idx_i   (if_idx),
    .if_entry_o (if_entry),
    .ex_idx_i   (ex_idx),
    .ex_entry_o (ex_entry),
    .wr_en_i    (wr_en),
    .wr_idx_i   (ex_idx),
    .wr_entry_i (wr_entry)
  );

  assign if_hit          = if_entry.valid && (if_entry.tag == if_tag);
  assign ex_hit          = ex_entry.valid && (ex_entry.tag == ex_tag);
  assign bus.pred_taken  = if_hit && if_entry.ctr[1];
  assign bus.pred_target = bus.pred_taken ? if_entry.target : '0;

  assign resolve     = (state_q == RUN) && bus.ex_valid && !bus.stall;
  assign ctl         = bus.ex_branch | bus.ex_jump;
  assign br_tgt      = bus.ex_br_pc[PC_W-1:0];
  assign train_taken = bus.ex_jump | bus.ex_pc_sel;
  // A non-control instruction that was predicted taken is an alias hit on someone else's entry.
  assign mis    = ctl ? ((bus.ex_pc_sel != bus.ex_pred_taken) ||
                         (bus.ex_pc_sel && (br_tgt != bus.ex_pred_target)))
                      : bus.ex_pred_taken;
  assign fix_pc = (ctl && bus.ex_pc_sel) ? br_tgt : bus.ex_pc + PC_W'(4);

  always_comb begin
    wr_en    = 1'b0;
    wr_entry = ex_entry;
    if (resolve) begin
      if (ctl) begin
        if (ex_hit) begin
          wr_en        = 1'b1;
          wr_entry.ctr = ctr_next(ex_entry.ctr, train_taken);
          if (train_taken) begin
            wr_entry.target = br_tgt;
          end
        end else if (train_taken) begin
          wr_en    = 1'b1;
          wr_entry = '{valid: 1'b1, tag: ex_tag, target: br_tgt, ctr: CTR_ALLOC};
        end
      end else if (ex_hit) begin
        wr_en          = 1'b1;
        wr_entry.valid = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q       <= RUN;
      redirect_pc_q <= '0;
      branch_cnt_q  <= '0;
      mis_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      redirect_pc_q <= redirect_pc_d;
      branch_cnt_q  <= branch_cnt_d;
      mis_cnt_q     <= mis_cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    redirect_pc_d = redirect_pc_q;
    branch_cnt_d  = branch_cnt_q;
    mis_cnt_d     = mis_cnt_q;
    case (state_q)
      RUN: begin
        redirect_pc_d = '0;
        if (resolve) begin
          branch_cnt_d = branch_cnt_q + CNT_W'(ctl);
          mis_cnt_d    = mis_cnt_q + CNT_W'(mis);
          if (mis) begin
            state_d       = REDIR;
            redirect_pc_d = fix_pc;
          end
        end
      end
      REDIR: begin
        // EX holds wrong-path work here; only a stall-free cycle releases the redirect.
        if (!bus.stall) begin
          state_d       = RUN;
          redirect_pc_d = '0;
        end
      end
    endcase
  end

  assign bus.redirect       = (state_q == REDIR);
  assign bus.flush_if_id    = (state_q == REDIR);
  assign bus.flush_id_ex    = (state_q == REDIR);
  assign bus.redirect_pc    = redirect_pc_q;
  assign bus.branch_cnt     = branch_cnt_q;
  assign bus.mispredict_cnt = mis_cnt_q;

  assign unused_bits = ^{bus.if_pc[1:0], bus.ex_br_pc[31:PC_W]};

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// tb/tb_branch_redirect_ctrl.sv - directed bench with per-cycle model comparison for branch_redirect_ctrl
module tb_branch_redirect_ctrl;

  localparam int PC_W  = 9;
  localparam int CNT_W = 4;
  localparam int N     = 16;
  localparam int PC_M  = 1 << PC_W;
  localparam int CNT_M = 1 << CNT_W;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  branch_redirect_ctrl_if #(.PC_W(PC_W), .CNT_W(CNT_W)) bus ();

  branch_redirect_ctrl #(.PC_W(PC_W), .BHT_ENTRIES(N), .CNT_W(CNT_W)) dut (
    .clk_i   (clk),
    .reset_i (reset),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  bit mv [N];
  int mg [N];
  int mt [N];
  int mc [N];
  bit m_redir;
  int m_rpc, m_b, m_m;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin : model
    int idx, tag, br, pc;
    bit ctl, tk, hit, mis;
    if (reset) begin
      m_redir = 0; m_rpc = 0; m_b = 0; m_m = 0;
      for (int i = 0; i < N; i++) begin
        mv[i] = 0; mg[i] = 0; mt[i] = 0; mc[i] = 1;
      end
    end else if (m_redir) begin
      if (!bus.stall) begin
        m_redir = 0; m_rpc = 0;
      end
    end else if (bus.ex_valid && !bus.stall) begin
      pc  = int'(bus.ex_pc);
      idx = (pc / 4) % N;
      tag = pc / (4 * N);
      br  = int'(bus.ex_br_pc % 32'(PC_M));
      ctl = bus.ex_branch || bus.ex_jump;
      tk  = bus.ex_jump || bus.ex_pc_sel;
      hit = mv[idx] && (mg[idx] == tag);
      if (ctl)
        mis = (bus.ex_pc_sel != bus.ex_pred_taken) ||
              (bus.ex_pc_sel && br != int'(bus.ex_pred_target));
      else
        mis = bus.ex_pred_taken;
      if (ctl) m_b = (m_b + 1) % CNT_M;
      if (mis) begin
        m_m = (m_m + 1) % CNT_M;
        m_redir = 1;
        m_rpc = (ctl && bus.ex_pc_sel) ? br : (pc + 4) % PC_M;
      end
      if (ctl && hit) begin
        mc[idx] = tk ? ((mc[idx] < 3) ? mc[idx] + 1 : 3) : ((mc[idx] > 0) ? mc[idx] - 1 : 0);
        if (tk) mt[idx] = br;
      end else if (ctl && tk) begin
        mv[idx] = 1; mg[idx] = tag; mt[idx] = br; mc[idx] = 2;
      end else if (!ctl && hit) begin
        mv[idx] = 0;
      end
    end
  end

  always @(negedge clk) begin : compare
    int i, t;
    bit pt;
    if (chk_en) begin
      i  = (int'(bus.if_pc) / 4) % N;
      t  = int'(bus.if_pc) / (4 * N);
      pt = mv[i] && (mg[i] == t) && (mc[i] >= 2);
      chk("pred_taken", 32'(bus.pred_taken), 32'(pt));
      chk("pred_target", 32'(bus.pred_target), pt ? mt[i] : 0);
      chk("redirect", 32'(bus.redirect), 32'(m_redir));
      chk("flush_if_id", 32'(bus.flush_if_id), 32'(m_redir));
      chk("flush_id_ex", 32'(bus.flush_id_ex), 32'(m_redir));
      chk("redirect_pc", 32'(bus.redirect_pc), m_rpc);
      chk("branch_cnt", 32'(bus.branch_cnt), m_b);
      chk("mispredict_cnt", 32'(bus.mispredict_cnt), m_m);
    end
  end

  task automatic idle();
    bus.ex_valid = 0; bus.ex_branch = 0; bus.ex_jump = 0; bus.ex_pc = '0;
    bus.ex_pc_sel = 0; bus.ex_br_pc = '0; bus.ex_pred_taken = 0; bus.ex_pred_target = '0;
  endtask

  task automatic ex(input logic br, input logic jp, input logic [8:0] pc, input logic sel,
                    input logic [31:0] tgt, input logic pt, input logic [8:0] ptgt);
    bus.ex_valid = 1; bus.ex_branch = br; bus.ex_jump = jp; bus.ex_pc = pc;
    bus.ex_pc_sel = sel; bus.ex_br_pc = tgt; bus.ex_pred_taken = pt; bus.ex_pred_target = ptgt;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1; bus.stall = 0; bus.if_pc = '0; idle();
    next();
    chk_en = 1;
    next();
    reset = 0; bus.if_pc = 9'h040;
    mid();
    chk("rst_pred_taken", 32'(bus.pred_taken), 0);
    chk("rst_pred_target", 32'(bus.pred_target), 0);
    chk("rst_redirect", 32'(bus.redirect), 0);
    chk("rst_branch_cnt", 32'(bus.branch_cnt), 0);
    chk("rst_mis_cnt", 32'(bus.mispredict_cnt), 0);
    next();

    // First taken beq, unpredicted
    ex(1, 0, 9'h040, 1, 32'h060, 0, 9'h000); next();
    ex(0, 0, 9'h100, 0, 32'h000, 1, 9'h000);
    mid();
    chk("mis1_redirect", 32'(bus.redirect), 1);
    chk("mis1_redirect_pc", 32'(bus.redirect_pc), 32'h060);
    chk("mis1_flush_if_id", 32'(bus.flush_if_id), 1);
    chk("mis1_mis_cnt", 32'(bus.mispredict_cnt), 1);
    chk("mis1_pred_taken", 32'(bus.pred_taken), 1);
    chk("mis1_pred_target", 32'(bus.pred_target), 32'h060);
    next();
    idle(); mid();
    chk("mis1_exit_redirect", 32'(bus.redirect), 0);
    next();

    ex(1, 0, 9'h040, 1, 32'h060, 1, 9'h060); next();
    ex(1, 0, 9'h040, 1, 32'h060, 1, 9'h060); next();
    idle(); mid();
    chk("hit_redirect", 32'(bus.redirect), 0);
    chk("hit_branch_cnt", 32'(bus.branch_cnt), 3);
    next();
    ex(1, 0, 9'h040, 0, 32'h060, 1, 9'h060); next();
    idle(); mid();
    chk("nt_redirect_pc", 32'(bus.redirect_pc), 32'h044);
    chk("nt_pred_taken", 32'(bus.pred_taken), 1);
    next();
    next();

    // Mispredict followed by three stalled cycles with junk in EX
    ex(1, 0, 9'h088, 1, 32'h0A0, 0, 9'h000); next();
    bus.stall = 1; ex(1, 0, 9'h040, 0, 32'h000, 1, 9'h060);
    for (int k = 0; k < 4; k++) begin
      if (k == 3) bus.stall = 0;
      mid();
      chk("stall_redirect", 32'(bus.redirect), 1);
      chk("stall_redirect_pc", 32'(bus.redirect_pc), 32'h0A0);
      next();
    end
    idle(); mid();
    chk("stall_exit_redirect", 32'(bus.redirect), 0);
    chk("stall_mis_cnt", 32'(bus.mispredict_cnt), 3);
    next();

    bus.stall = 1; ex(0, 0, 9'h0C0, 0, 32'h000, 1, 9'h000); next();
    bus.stall = 0;
    mid();
    chk("runstall_mis_cnt", 32'(bus.mispredict_cnt), 3);
    next();
    idle(); mid();
    chk("alias_redirect_pc", 32'(bus.redirect_pc), 32'h0C4);
    next();
    next();

    // JALR at the top of the PC space, then a wrapping not-taken fix
    ex(0, 1, 9'h1FC, 1, 32'h0000_0A34, 0, 9'h000); next();
    idle(); bus.if_pc = 9'h1FC; mid();
    chk("jalr_redirect_pc", 32'(bus.redirect_pc), 32'h034);
    chk("jalr_pred_target", 32'(bus.pred_target), 32'h034);
    next();
    next();
    ex(1, 0, 9'h1FC, 0, 32'h000, 1, 9'h034); next();
    idle(); mid();
    chk("wrap_redirect", 32'(bus.redirect), 1);
    chk("wrap_redirect_pc", 32'(bus.redirect_pc), 32'h000);
    chk("wrap_pred_taken", 32'(bus.pred_taken), 0);
    next();
    next();

    bus.if_pc = 9'h040; ex(0, 0, 9'h040, 0, 32'h000, 1, 9'h060); next();
    idle(); mid();
    chk("inval_pred_taken", 32'(bus.pred_taken), 0);
    next();
    next();

    // Reset while redirecting
    ex(1, 0, 9'h088, 1, 32'h0B0, 1, 9'h0A0); next();
    idle(); bus.if_pc = 9'h088; reset = 1; mid();
    chk("pre_rst_redirect", 32'(bus.redirect), 1);
    chk("pre_rst_pred_target", 32'(bus.pred_target), 32'h0B0);
    next();
    reset = 0; mid();
    chk("post_rst_redirect", 32'(bus.redirect), 0);
    chk("post_rst_pred_taken", 32'(bus.pred_taken), 0);
    next();

    for (int k = 0; k < 17; k++) begin
      ex(1, 0, 9'h100, 0, 32'h000, 0, 9'h000); next();
    end
    idle(); mid();
    chk("cnt_wrap_branch_cnt", 32'(bus.branch_cnt), 1);
    chk("cnt_wrap_mis_cnt", 32'(bus.mispredict_cnt), 0);
    next();

    chk_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
